// File: rtl/boot_mem_responder_if.sv
// Bus bundle between boot_mem_responder and its surroundings: the boot byte
// stream, the CPU reset and the CPU instruction/data memory ports.
interface boot_mem_responder_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_err;
  logic [ADDR_W:0]   load_words;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] ram_addr2;
  logic [31:0]       ram_in2;
  logic              mem_w_en;
  logic [31:0]       ram_data2;

  // Driven by the top level / CPU side.
  modport master (
    output load_valid, load_byte, load_last, pc, ram_addr2, ram_in2, mem_w_en,
    input  load_ready, load_err, load_words, cpu_rst_n, instr, ram_data2
  );

  // Driven by the memory responder.
  modport slave (
    input  load_valid, load_byte, load_last, pc, ram_addr2, ram_in2, mem_w_en,
    output load_ready, load_err, load_words, cpu_rst_n, instr, ram_data2
  );
endinterface

// File: rtl/boot_mem_responder.sv
// Dual-port 32-bit boot RAM: loads a little-endian byte image after reset, holds the
// CPU in reset until the image is written, then serves fetch and load/store ports.
// Optional macro BOOT_MEM_WR_FWD_EN: port-2 read-during-write returns the new data.
module boot_mem_responder #(
  parameter int unsigned DEPTH         = 2048,
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boot_mem_responder_if.slave   bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_FLUSH   = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [1:0]           byte_idx_q;
  logic [23:0]          word_buf_q;
  logic [WCNT_W-1:0]    words_q;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 cpu_rst_n_q;
  logic [DATA_W-1:0]    instr_q;
  logic [DATA_W-1:0]    data2_q;

  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 accept_c;
  logic                 full_c;
  logic                 ld_we_c;
  logic [DATA_W-1:0]    ld_wdata_c;
  logic                 mem_we_c;
  logic [ADDR_W-1:0]    mem_waddr_c;
  logic [DATA_W-1:0]    mem_wdata_c;

  assign accept_c = (state_q == S_LOAD) && bus.load_valid;
  // words_q doubles as the loader write pointer; reaching DEPTH means the RAM is full.
  assign full_c   = (words_q == WCNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept_c && bus.load_last) begin
          state_d = (byte_idx_q == 2'd3) ? S_RELEASE : S_FLUSH;
        end
      end
      S_FLUSH:   state_d = S_RELEASE;
      S_RELEASE: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = S_RUN;
        end
      end
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_LOAD;
    endcase
  end

  // Output/control logic: loader word write and RAM write-port mux
  always_comb begin
    ld_we_c    = 1'b0;
    ld_wdata_c = '0;
    unique case (state_q)
      S_LOAD: begin
        if (accept_c && (byte_idx_q == 2'd3)) begin
          ld_we_c    = 1'b1;
          ld_wdata_c = {bus.load_byte, word_buf_q};
        end
      end
      S_FLUSH: begin
        ld_we_c    = 1'b1;
        ld_wdata_c = {8'h00, word_buf_q};
      end
      default: begin
        ld_we_c    = 1'b0;
        ld_wdata_c = '0;
      end
    endcase

    if (state_q == S_RUN) begin
      mem_we_c    = bus.mem_w_en;
      mem_waddr_c = bus.ram_addr2;
      mem_wdata_c = bus.ram_in2;
    end else begin
      mem_we_c    = ld_we_c && !full_c;
      mem_waddr_c = words_q[ADDR_W-1:0];
      mem_wdata_c = ld_wdata_c;
    end
  end

  // Byte packer; upper lanes are cleared per word so a flushed partial word is zero-filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      word_buf_q <= '0;
    end else if (accept_c) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      unique case (byte_idx_q)
        2'd0:    word_buf_q <= {16'h0000, bus.load_byte};
        2'd1:    word_buf_q[15:8]  <= bus.load_byte;
        2'd2:    word_buf_q[23:16] <= bus.load_byte;
        default: word_buf_q <= '0;
      endcase
    end
  end

  // Loader word count and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      err_q   <= 1'b0;
    end else if (ld_we_c) begin
      if (full_c) begin
        err_q   <= 1'b1;
      end else begin
        words_q <= words_q + WCNT_W'(1);
      end
    end
  end

  // Release delay counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_d == S_RELEASE) && (state_q != S_RELEASE)) begin
      cnt_q <= CNT_W'(RELEASE_DELAY);
    end else if ((state_q == S_RELEASE) && (cnt_q != CNT_W'(0))) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Registered handshake and CPU reset, derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b1;
      cpu_rst_n_q <= 1'b0;
    end else begin
      ready_q     <= (state_d == S_LOAD);
      cpu_rst_n_q <= (state_d == S_RUN);
    end
  end

  // RAM storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Synchronous read ports, zero outside RUN; port 1 is always read-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      data2_q <= '0;
    end else if (state_q == S_RUN) begin
      instr_q <= mem[bus.pc];
`ifdef BOOT_MEM_WR_FWD_EN
      data2_q <= bus.mem_w_en ? bus.ram_in2 : mem[bus.ram_addr2];
`else
      data2_q <= mem[bus.ram_addr2];
`endif
    end else begin
      instr_q <= '0;
      data2_q <= '0;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.load_err   = err_q;
  assign bus.load_words = words_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.instr      = instr_q;
  assign bus.ram_data2  = data2_q;

endmodule
